aes_key_expand_seq: RTL

- Iterative AES key-expansion engine, successor to the single-word combinational round-key sub-block.
- Key length is parametrised: 128, 192 or 256 bits.
- Generates the full FIPS-197 key schedule, one 32-bit word per cycle, on a valid/ready stream with word index.
- Sits between the key register and the cipher round datapath.

---
 rtl/aes_key_expand_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key-expansion engine: streams the FIPS-197 key schedule one word per cycle.
// Optional macro AES_KEYEXP_RDPORT_EN adds a schedule store with a registered random-read port.
module aes_key_expand_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [31:0]         word_data,
    output logic [5:0]          word_idx,
    output logic                done
`ifdef AES_KEYEXP_RDPORT_EN
    ,
    input  logic [5:0]          rd_idx,
    output logic [31:0]         rd_data,
    output logic                sched_ok
`endif
);

    localparam int NK       = KEY_BITS / 32;
    localparam int NR       = NK + 6;
    localparam int LAST_IDX = 4 * NR + 3;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] win_r [NK];
    logic [7:0]  rcon_r;
    logic [2:0]  pos_r;
    logic        busy_r;
    logic        valid_r;
    logic        done_r;
    logic [31:0] data_r;
    logic [5:0]  idx_r;

    logic        hs_s;
    logic        last_hs_s;
    logic        from_key_s;
    logic        rcon_adv_s;
    logic [2:0]  nxt_pos_s;
    logic [5:0]  nxt_idx_s;
    logic [31:0] temp_s;
    logic [31:0] calc_word_s;
    logic [31:0] key_word_s;
    logic [31:0] nxt_word_s;

    // Next schedule word: window holds w[i-NK..i-1] with the oldest word in slot 0.
    always_comb begin
        hs_s       = valid_r && word_ready;
        last_hs_s  = hs_s && (idx_r == 6'(LAST_IDX));
        nxt_pos_s  = (pos_r == 3'(NK - 1)) ? 3'd0 : pos_r + 3'd1;
        nxt_idx_s  = idx_r + 6'd1;
        from_key_s = (idx_r < 6'(NK - 1));
        rcon_adv_s = 1'b0;
        temp_s     = win_r[NK-1];
        if (nxt_pos_s == 3'd0) begin
            temp_s     = sub_word(rot_word(win_r[NK-1])) ^ {rcon_r, 24'h000000};
            rcon_adv_s = !from_key_s;
        end else if (NK == 8 && nxt_pos_s == 3'd4) begin
            temp_s = sub_word(win_r[NK-1]);
        end else begin
            temp_s = win_r[NK-1];
        end
        calc_word_s = win_r[0] ^ temp_s;
        key_word_s  = 32'h0;
        for (int j = 0; j < NK; j++) begin
            key_word_s = (nxt_pos_s == 3'(j)) ? win_r[j] : key_word_s;
        end
        nxt_word_s = from_key_s ? key_word_s : calc_word_s;
    end

    // Control FSM with registered stream outputs and the sliding key window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            win_r   <= '{default: 32'h0};
            rcon_r  <= 8'h01;
            pos_r   <= 3'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= 32'h0;
            idx_r   <= 6'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        for (int j = 0; j < NK; j++) begin
                            win_r[j] <= key_in[KEY_BITS-1-32*j -: 32];
                        end
                        rcon_r  <= 8'h01;
                        pos_r   <= 3'd0;
                        idx_r   <= 6'd0;
                        data_r  <= key_in[KEY_BITS-1 -: 32];
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= S_EMIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (last_hs_s) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else if (hs_s) begin
                        data_r <= nxt_word_s;
                        idx_r  <= nxt_idx_s;
                        pos_r  <= nxt_pos_s;
                        if (!from_key_s) begin
                            for (int j = 0; j < NK - 1; j++) begin
                                win_r[j] <= win_r[j+1];
                            end
                            win_r[NK-1] <= calc_word_s;
                        end
                        if (rcon_adv_s) begin
                            rcon_r <= xtime(rcon_r);
                        end
                    end else begin
                        state_r <= S_EMIT;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign word_valid = valid_r;
    assign word_data  = data_r;
    assign word_idx   = idx_r;
    assign done       = done_r;

`ifdef AES_KEYEXP_RDPORT_EN
    logic [31:0] store_r [LAST_IDX+1];
    logic [31:0] rd_data_r;
    logic        sched_ok_r;

    // Schedule store filled in stream order, read back with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_r    <= '{default: 32'h0};
            rd_data_r  <= 32'h0;
            sched_ok_r <= 1'b0;
        end else begin
            if (hs_s) begin
                store_r[idx_r] <= data_r;
            end
            rd_data_r <= (rd_idx > 6'(LAST_IDX)) ? 32'h0 : store_r[rd_idx];
            if (state_r == S_IDLE && start) begin
                sched_ok_r <= 1'b0;
            end else if (last_hs_s) begin
                sched_ok_r <= 1'b1;
            end else begin
                sched_ok_r <= sched_ok_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign sched_ok = sched_ok_r;
`endif

endmodule
